// File: rtl/scd_scad_loop_if.sv
// Bundles the CRAM controls, AR word and SCAD/FE/SC results of scd_scad_loop.
// The datapath drives through the slave modport; the microcode sequencer uses master.
interface scd_scad_loop_if #(
  parameter int WORD_W = 36,
  parameter int SC_W   = 10
);
  logic [0:WORD_W-1] AR;
  logic [0:8]        CRAM_MAGIC;
  logic [2:0]        CRAM_SCAD;
  logic [1:0]        CRAM_SCADA;
  logic [1:0]        CRAM_SCADB;
  logic              LOAD_FE;
  logic              LOAD_SC;
  logic              START;
  logic              ABORT;
  logic              DIAG_READ;
  logic [SC_W-1:0]   SCAD;
  logic              SCAD_OVF;
  logic [SC_W-1:0]   FE;
  logic [SC_W-1:0]   SC;
  logic              SC_GE_WORD;
  logic              BUSY;
  logic              STEP;
  logic              DONE;
  logic [0:WORD_W-1] EBUS;

  modport master (
    output AR, CRAM_MAGIC, CRAM_SCAD, CRAM_SCADA, CRAM_SCADB,
    output LOAD_FE, LOAD_SC, START, ABORT, DIAG_READ,
    input  SCAD, SCAD_OVF, FE, SC, SC_GE_WORD, BUSY, STEP, DONE, EBUS
  );

  modport slave (
    input  AR, CRAM_MAGIC, CRAM_SCAD, CRAM_SCADA, CRAM_SCADB,
    input  LOAD_FE, LOAD_SC, START, ABORT, DIAG_READ,
    output SCAD, SCAD_OVF, FE, SC, SC_GE_WORD, BUSY, STEP, DONE, EBUS
  );
endinterface

// File: rtl/scd_scad_loop.sv
// Shift-count/exponent datapath: SCADA/SCADB muxes, SCAD ALU, FE/SC registers and SC countdown loop.
// Optional diagnostic EBUS readback of {BUSY, FE, SC} is enabled by defining SCD_DIAG_READ_EN.
module scd_scad_loop #(
  parameter int WORD_W = 36,
  parameter int SC_W   = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  scd_scad_loop_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_t;

  // Field extraction is done at least 9 bits wide so narrow SC_W builds truncate cleanly.
  localparam int XW = (SC_W > 9) ? SC_W : 9;
  localparam logic [SC_W-1:0] WORD_LIM = SC_W'(WORD_W);

  state_t          state_q, state_d;
  logic [SC_W-1:0] fe_q, fe_d;
  logic [SC_W-1:0] sc_q, sc_d;

  logic [XW-1:0]   exp_x, pos_x, size_x, arsg_x, magic_x;
  logic [SC_W-1:0] scada, scadb, addend, scad;
  logic [SC_W:0]   sum_x;
  logic            cin, scad_ovf, step, done, busy;

  always_comb begin
    exp_x   = XW'(bus.AR[1:8]);
    pos_x   = XW'(bus.AR[0:5]);
    size_x  = XW'(bus.AR[6:11]);
    arsg_x  = XW'($signed(bus.AR[0:8]));
    magic_x = XW'($signed(bus.CRAM_MAGIC));

    case (bus.CRAM_SCADA)
      2'd0:    scada = fe_q;
      2'd1:    scada = exp_x[SC_W-1:0];
      2'd2:    scada = pos_x[SC_W-1:0];
      default: scada = magic_x[SC_W-1:0];
    endcase

    case (bus.CRAM_SCADB)
      2'd0:    scadb = sc_q;
      2'd1:    scadb = size_x[SC_W-1:0];
      2'd2:    scadb = arsg_x[SC_W-1:0];
      default: scadb = magic_x[SC_W-1:0];
    endcase
  end

  // All arithmetic ops share one adder: A + addend + cin, one guard bit for overflow.
  always_comb begin
    addend = scadb;
    cin    = 1'b0;
    case (bus.CRAM_SCAD)
      3'd2:    addend = ~scadb;
      3'd3: begin
        addend = ~scadb;
        cin    = 1'b1;
      end
      3'd6:    addend = '1;
      3'd7: begin
        addend = '0;
        cin    = 1'b1;
      end
      default: addend = scadb;
    endcase

    sum_x = {scada[SC_W-1], scada} + {addend[SC_W-1], addend} + (SC_W+1)'(cin);

    scad     = sum_x[SC_W-1:0];
    scad_ovf = sum_x[SC_W] ^ sum_x[SC_W-1];
    case (bus.CRAM_SCAD)
      3'd0: begin
        scad     = scada;
        scad_ovf = 1'b0;
      end
      3'd1: begin
        scad     = scada | scadb;
        scad_ovf = 1'b0;
      end
      3'd5: begin
        scad     = scada & scadb;
        scad_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  // Loop control: ABORT wins over a step; a negative SC ends the loop with DONE.
  always_comb begin
    state_d = state_q;
    fe_d    = bus.LOAD_FE ? scad : fe_q;
    sc_d    = sc_q;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.LOAD_SC) sc_d = scad;
        if (bus.START)   state_d = RUN;
      end
      RUN: begin
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (sc_q[SC_W-1]) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          step = 1'b1;
          sc_d = sc_q - SC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fe_q    <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      fe_q    <= fe_d;
      sc_q    <= sc_d;
    end
  end

  assign busy = (state_q == RUN);

  assign bus.SCAD       = scad;
  assign bus.SCAD_OVF   = scad_ovf;
  assign bus.FE         = fe_q;
  assign bus.SC         = sc_q;
  assign bus.SC_GE_WORD = ($signed(sc_q) >= $signed(WORD_LIM));
  assign bus.BUSY       = busy;
  assign bus.STEP       = step;
  assign bus.DONE       = done;

`ifdef SCD_DIAG_READ_EN
  assign bus.EBUS = bus.DIAG_READ ? WORD_W'({busy, fe_q, sc_q}) : '0;
  logic diag_unused;
  assign diag_unused = ^bus.AR;
`else
  assign bus.EBUS = '0;
  logic diag_unused;
  assign diag_unused = ^{bus.DIAG_READ, bus.AR};
`endif
endmodule
